// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and default constants for the instruction fetch sequencer.
//   state_t              : fetch controller states
//   DEFAULT_RESET_VECTOR : first fetch address / base of the instruction window
//   DEFAULT_HALT_WORD    : instruction encoding that stops fetch
// ----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
   localparam logic [31:0] DEFAULT_HALT_WORD    = 32'h0000_000C;

endpackage

// File: rtl/imem_bank.sv
// ----------------------------------------------------------------------------
// imem_bank
// Single-port XLEN x DEPTH instruction RAM, synchronous write and read.
// Ports:
//   clk    : clock
//   reset  : async active-high, clears only the read data register
//   en     : port enable (read or write this cycle)
//   we     : write strobe (with en)
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data, holds when no read is performed
// ----------------------------------------------------------------------------
module imem_bank #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   // The array itself is never reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   // Read data only changes on an actual read, so a stalled fetch keeps its word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Sequential instruction fetch over a private instruction RAM with load mode,
// stall, redirect, address-fault and halt handling.
// Ports:
//   clk, reset         : clock, async active-high reset
//   init_mode          : enter/stay in memory load mode
//   init_we/addr/data  : load write strobe, word index, word
//   stall              : hold fetch
//   redirect/_pc       : taken branch/jump and its target
//   pc                 : current fetch address
//   instr/instr_pc     : fetched word and its address
//   instr_valid        : instr/instr_pc valid
//   fault, halted      : sticky status flags
// ----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter int              IMEM_DEPTH   = 4096,
   parameter logic [XLEN-1:0] HALT_WORD    = XLEN'(DEFAULT_HALT_WORD),
   localparam int             ADDR_W       = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_mode,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [XLEN-1:0]   init_data,
   input  logic              stall,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   instr,
   output logic [XLEN-1:0]   instr_pc,
   output logic              instr_valid,
   output logic              fault,
   output logic              halted
);

   localparam logic [XLEN-1:0] WINDOW_BYTES = XLEN'(4 * IMEM_DEPTH);

   state_t            state, state_n;
   logic [XLEN-1:0]   pc_n, instr_pc_n;
   logic              instr_valid_n;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   seq_pc;

   // Unsigned offset compare also rejects addresses below the window,
   // since they wrap to very large offsets.
   function automatic logic in_window(input logic [XLEN-1:0] a);
      return ((a - RESET_VECTOR) < WINDOW_BYTES) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [ADDR_W-1:0] word_index(input logic [XLEN-1:0] a);
      return ADDR_W'((a - RESET_VECTOR) >> 2);
   endfunction

   assign seq_pc = pc + XLEN'(4);
   assign fault  = (state == FAULT);
   assign halted = (state == HALT);

   imem_bank #(
      .XLEN   (XLEN),
      .DEPTH  (IMEM_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_imem (
      .clk   (clk),
      .reset (reset),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (init_data),
      .rdata (instr)
   );

   // State and fetch-tracking registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_VECTOR;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr_pc    <= instr_pc_n;
         instr_valid <= instr_valid_n;
      end
   end

   // Next-state and memory port control. init_mode overrides every state;
   // in RUN a halt word already on the output wins over a newer redirect,
   // and a redirect wins over stall.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      instr_pc_n    = instr_pc;
      instr_valid_n = instr_valid;
      mem_en        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = word_index(pc);

      if (state == LOAD) begin
         mem_en   = init_we;
         mem_we   = init_we;
         mem_addr = init_addr;
      end

      if (init_mode) begin
         state_n       = LOAD;
         pc_n          = RESET_VECTOR;
         instr_valid_n = 1'b0;
      end else begin
         unique case (state)
            LOAD: begin
               state_n       = RUN;
               pc_n          = RESET_VECTOR;
               instr_valid_n = 1'b0;
            end
            RUN: begin
               if (instr_valid && (instr == HALT_WORD)) begin
                  state_n       = HALT;
                  instr_valid_n = 1'b0;
               end else if (redirect) begin
                  pc_n          = redirect_pc;
                  instr_valid_n = 1'b0;
                  if (!in_window(redirect_pc)) begin
                     state_n = FAULT;
                  end
               end else if (!stall) begin
                  pc_n = seq_pc;
                  if (!in_window(seq_pc)) begin
                     state_n       = FAULT;
                     instr_valid_n = 1'b0;
                  end else begin
                     mem_en        = 1'b1;
                     instr_pc_n    = pc;
                     instr_valid_n = 1'b1;
                  end
               end
            end
            FAULT, HALT: begin
               instr_valid_n = 1'b0;
            end
         endcase
      end
   end

endmodule
